// File: rtl/cpu_datapath.sv
// cpu_datapath: datapath stage driven by the instruction control unit.
// Holds the instruction register, 2-bit step counter, general registers
// R0-R7, operand register A, result register G with carry/zero flags, the
// ALU and the shared bus multiplexer.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   run               step counter advance enable
//   DIN               external data / instruction input
//   IRin, clear       IR load strobe; end-of-instruction (zero counter, fetch IR)
//   Rout, Rin         bus source register index; register write enables
//   Ain, Gin, Gout    load A; load G and flags; drive G onto the bus
//   DINout            drive DIN onto the bus
//   alu_op            00 pass, 01 add, 10 sub, 11 pass
//   IR, counter       registered instruction and step count to the control unit
//   bus               current bus value (combinational)
//   carry, zero       flags captured with the last Gin
//   dbg_sel, dbg_reg  combinational debug read of R[dbg_sel]
module cpu_datapath #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned IR_W   = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              IRin,
    input  logic              clear,
    input  logic [2:0]        Rout,
    input  logic [7:0]        Rin,
    input  logic              Ain,
    input  logic              Gin,
    input  logic              Gout,
    input  logic              DINout,
    input  logic [1:0]        alu_op,
    output logic [IR_W-1:0]   IR,
    output logic [1:0]        counter,
    output logic [DATA_W-1:0] bus,
    output logic              carry,
    output logic              zero,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_reg
);

    localparam int unsigned NUM_REGS = 8;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] g_reg;

    // One extra bit holds the carry out of an add or the borrow of a subtract.
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    // Bus source priority: DIN, then G, then the selected register.
    always_comb begin
        bus = regs[Rout];
        if (DINout) begin
            bus = DIN;
        end else if (Gout) begin
            bus = g_reg;
        end
    end

    assign dbg_reg = regs[dbg_sel];

    // ALU on A and the bus; reserved opcode behaves as pass.
    always_comb begin
        alu_wide = {1'b0, bus};
        case (alu_op)
            ALU_ADD:  alu_wide = {1'b0, a_reg} + {1'b0, bus};
            ALU_SUB:  alu_wide = {1'b0, a_reg} - {1'b0, bus};
            ALU_PASS: alu_wide = {1'b0, bus};
            default:  alu_wide = {1'b0, bus};
        endcase
    end

    // For a subtract the top bit of the wide difference is set exactly when A < bus.
    assign alu_result = alu_wide[DATA_W-1:0];
    assign alu_carry  = alu_wide[DATA_W];

    // General registers: every enabled register samples the pre-edge bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (Rin[i]) begin
                    regs[i] <= bus;
                end
            end
        end
    end

    // Operand register A.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg <= '0;
        end else if (Ain) begin
            a_reg <= bus;
        end
    end

    // Result register G and flags, captured together.
    always_ff @(posedge clock) begin
        if (reset) begin
            g_reg <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (Gin) begin
            g_reg <= alu_result;
            carry <= alu_carry;
            zero  <= (alu_result == '0);
        end
    end

    // Step counter: clear beats run; wraps naturally at 2 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= 2'd0;
        end else if (clear) begin
            counter <= 2'd0;
        end else if (run) begin
            counter <= counter + 2'd1;
        end
    end

    // Instruction register: loaded on explicit strobe or end-of-instruction fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            IR <= '0;
        end else if (IRin || clear) begin
            IR <= IR_W'(DIN);
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized and directed bench for cpu_datapath with a scoreboard queue.
module tb_cpu_datapath;

    logic       clock;
    logic       reset;
    logic       run;
    logic [8:0] DIN;
    logic       IRin;
    logic       clear;
    logic [2:0] Rout;
    logic [7:0] Rin;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       DINout;
    logic [1:0] alu_op;
    logic [8:0] IR;
    logic [1:0] counter;
    logic [8:0] bus;
    logic       carry;
    logic       zero;
    logic [2:0] dbg_sel;
    logic [8:0] dbg_reg;

    cpu_datapath #(.DATA_W(9), .IR_W(9)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .DIN     (DIN),
        .IRin    (IRin),
        .clear   (clear),
        .Rout    (Rout),
        .Rin     (Rin),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .DINout  (DINout),
        .alu_op  (alu_op),
        .IR      (IR),
        .counter (counter),
        .bus     (bus),
        .carry   (carry),
        .zero    (zero),
        .dbg_sel (dbg_sel),
        .dbg_reg (dbg_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       reset;
        logic       run;
        logic       irin;
        logic       clear;
        logic [2:0] rout;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic [1:0] alu_op;
        logic [8:0] din;
        logic [2:0] dbg_sel;
    } stim_t;

    typedef struct packed {
        logic [8:0] ir;
        logic [1:0] cnt;
        logic       cy;
        logic       zf;
        logic [8:0] bus;
        logic [8:0] dbg;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    // Reference state kept as plain integers.
    int m_r [8];
    int m_a, m_g, m_ir, m_cnt, m_cy, m_zf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Apply one cycle of stimulus, queue the expected outputs for this cycle,
    // then advance the reference model across the coming edge.
    task automatic step(input stim_t s);
        exp_t e;
        int bv, res, sum;
        @(posedge clock);
        #1;
        reset = s.reset; run = s.run; IRin = s.irin; clear = s.clear;
        Rout = s.rout; Rin = s.rin; Ain = s.ain; Gin = s.gin; Gout = s.gout;
        DINout = s.dinout; alu_op = s.alu_op; DIN = s.din; dbg_sel = s.dbg_sel;

        if (s.dinout)     bv = int'(s.din);
        else if (s.gout)  bv = m_g;
        else              bv = m_r[s.rout];

        e.ir  = 9'(m_ir);
        e.cnt = 2'(m_cnt);
        e.cy  = 1'(m_cy);
        e.zf  = 1'(m_zf);
        e.bus = 9'(bv);
        e.dbg = 9'(m_r[s.dbg_sel]);
        q.push_back(e);

        if (s.reset) begin
            for (int i = 0; i < 8; i++) m_r[i] = 0;
            m_a = 0; m_g = 0; m_ir = 0; m_cnt = 0; m_cy = 0; m_zf = 0;
        end else begin
            if (s.gin) begin
                if (s.alu_op == 2'b01) begin
                    sum  = m_a + bv;
                    res  = sum % 512;
                    m_cy = (sum >= 512) ? 1 : 0;
                end else if (s.alu_op == 2'b10) begin
                    res  = (m_a - bv + 512) % 512;
                    m_cy = (m_a < bv) ? 1 : 0;
                end else begin
                    res  = bv;
                    m_cy = 0;
                end
                m_g  = res;
                m_zf = (res == 0) ? 1 : 0;
            end
            for (int i = 0; i < 8; i++) if (s.rin[i]) m_r[i] = bv;
            if (s.ain) m_a = bv;
            if (s.clear)     m_cnt = 0;
            else if (s.run)  m_cnt = (m_cnt + 1) % 4;
            if (s.irin || s.clear) m_ir = int'(s.din);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("IR",      32'(IR),      32'(e.ir));
            chk("counter", 32'(counter), 32'(e.cnt));
            chk("carry",   32'(carry),   32'(e.cy));
            chk("zero",    32'(zero),    32'(e.zf));
            chk("bus",     32'(bus),     32'(e.bus));
            chk("dbg_reg", 32'(dbg_reg), 32'(e.dbg));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        int drain;

        reset = 1'b1; run = 0; IRin = 0; clear = 0; Rout = 0; Rin = 0; Ain = 0;
        Gin = 0; Gout = 0; DINout = 0; alu_op = 0; DIN = 0; dbg_sel = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_a = 0; m_g = 0; m_ir = 0; m_cnt = 0; m_cy = 0; m_zf = 0;
        repeat (2) @(posedge clock);

        // DIN load into R1, then move R1 -> R3.
        s = idle(); s.dinout = 1; s.din = 9'h0A5; s.rin = 8'h02; step(s);
        s = idle(); s.rout = 3'd1; s.rin = 8'h08; step(s);
        #1 chk("move_bus", 32'(bus), 32'h0A5);
        s = idle(); s.dbg_sel = 3'd3; step(s);
        #1 chk("move_r3", 32'(dbg_reg), 32'h0A5);

        // ADD with wrap: 0x1F0 + 0x020.
        s = idle(); s.dinout = 1; s.din = 9'h1F0; s.rin = 8'h01; step(s);
        s = idle(); s.dinout = 1; s.din = 9'h020; s.rin = 8'h02; step(s);
        s = idle(); s.rout = 3'd0; s.ain = 1; step(s);
        s = idle(); s.rout = 3'd1; s.alu_op = 2'b01; s.gin = 1; step(s);
        s = idle(); s.gout = 1; s.rin = 8'h01; step(s);
        #1 chk("add_g", 32'(bus), 32'h010);
        chk("add_carry", 32'(carry), 32'd1);
        chk("add_zero", 32'(zero), 32'd0);
        s = idle(); s.dbg_sel = 3'd0; step(s);
        #1 chk("add_r0", 32'(dbg_reg), 32'h010);

        // SUB with borrow, then SUB to zero.
        s = idle(); s.dinout = 1; s.din = 9'd5; s.ain = 1; step(s);
        s = idle(); s.dinout = 1; s.din = 9'd7; s.alu_op = 2'b10; s.gin = 1; step(s);
        s = idle(); s.gout = 1; step(s);
        #1 chk("sub_g", 32'(bus), 32'h1FE);
        chk("sub_borrow", 32'(carry), 32'd1);
        s = idle(); s.dinout = 1; s.din = 9'd7; s.ain = 1; step(s);
        s = idle(); s.dinout = 1; s.din = 9'd7; s.alu_op = 2'b10; s.gin = 1; step(s);
        s = idle(); s.gout = 1; step(s);
        #1 chk("subz_g", 32'(bus), 32'h000);
        chk("subz_zero", 32'(zero), 32'd1);
        chk("subz_carry", 32'(carry), 32'd0);

        // Counter wrap, clear with fetch, and reset over clear.
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.run = 1; step(s);
        end
        s = idle(); step(s);
        #1 chk("cnt_wrap", 32'(counter), 32'd1);
        s = idle(); s.clear = 1; s.run = 1; s.din = 9'h0C8; step(s);
        s = idle(); step(s);
        #1 chk("clr_cnt", 32'(counter), 32'd0);
        chk("clr_ir", 32'(IR), 32'h0C8);
        s = idle(); s.run = 1; step(s);
        s = idle(); s.clear = 1; s.run = 1; s.reset = 1; s.din = 9'h0C8; step(s);
        s = idle(); step(s);
        #1 chk("rst_clr_cnt", 32'(counter), 32'd0);
        chk("rst_clr_ir", 32'(IR), 32'd0);

        // Same-register read/write, multi-hot write, bus priority.
        s = idle(); s.dinout = 1; s.din = 9'h011; s.rin = 8'h04; step(s);
        s = idle(); s.rout = 3'd2; s.rin = 8'h84; step(s);
        s = idle(); s.dbg_sel = 3'd7; step(s);
        #1 chk("multi_r7", 32'(dbg_reg), 32'h011);
        s = idle(); s.dbg_sel = 3'd2; s.dinout = 1; s.gout = 1; s.din = 9'h123; step(s);
        #1 chk("prio_bus", 32'(bus), 32'h123);
        chk("hazard_r2", 32'(dbg_reg), 32'h011);

        // Reset in the middle of an instruction with G = 0x055.
        s = idle(); s.dinout = 1; s.din = 9'h055; s.gin = 1; s.alu_op = 2'b00; step(s);
        s = idle(); s.run = 1; step(s);
        s = idle(); s.run = 1; step(s);
        s = idle(); s.gout = 1; step(s);
        #1 chk("pre_rst_cnt", 32'(counter), 32'd2);
        chk("pre_rst_g", 32'(bus), 32'h055);
        s = idle(); s.reset = 1; s.run = 1; step(s);
        s = idle(); s.gout = 1; step(s);
        #1 chk("rst_cnt", 32'(counter), 32'd0);
        chk("rst_g", 32'(bus), 32'd0);
        chk("rst_ir", 32'(IR), 32'd0);
        for (int i = 0; i < 8; i++) begin
            s = idle(); s.dbg_sel = 3'(i); step(s);
            #1 chk("rst_reg", 32'(dbg_reg), 32'd0);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            s.reset   = ($urandom_range(0, 59) == 0);
            s.run     = 1'($urandom_range(0, 1));
            s.irin    = ($urandom_range(0, 7) == 0);
            s.clear   = ($urandom_range(0, 7) == 0);
            s.rout    = 3'($urandom_range(0, 7));
            s.rin     = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            s.ain     = 1'($urandom_range(0, 1));
            s.gin     = 1'($urandom_range(0, 1));
            s.gout    = ($urandom_range(0, 3) == 0);
            s.dinout  = ($urandom_range(0, 2) == 0);
            s.alu_op  = 2'($urandom_range(0, 3));
            s.din     = ($urandom_range(0, 9) == 0) ? 9'h000 : 9'($urandom_range(0, 511));
            s.dbg_sel = 3'($urandom_range(0, 7));
            step(s);
        end

        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        if (q.size() > 0) begin
            chk("drain", 32'(q.size()), 32'd0);
        end
        @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
